// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue/completion controller around the execute-stage ALU. Takes one
//   decoded op per valid/ready handshake. Single-cycle ops complete in one
//   cycle. Multiply runs for MUL_CYCLES cycles. Divide/modulus uses a
//   32-step restoring divider. Upstream issue is stalled while a multi-cycle
//   op is in flight. The sequencer owns the compare flags. Every result is
//   returned through a held valid/ready output register.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    op handshake (op, A, B sampled on transfer)
//   op[3:0]                0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 or,
//                          7 and, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr
//   A[31:0], B[31:0]       operands
//   out_valid / out_ready  result handshake toward writeback
//   result[31:0]           held result
//   flag_eq, flag_gt       A==B and unsigned A>B from the last completed cmp
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_eq,
    output logic        flag_gt
);

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;

    localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [4:0] MUL_LOAD  = 5'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} stateT;

    // Shift amounts use the full 32-bit B; anything >= 32 saturates.
    function automatic logic [DATA_W-1:0] shiftLeft(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] amt);
        if (|amt[DATA_W-1:5]) shiftLeft = '0;
        else                  shiftLeft = a << amt[4:0];
    endfunction

    function automatic logic [DATA_W-1:0] shiftRightLogic(input logic [DATA_W-1:0] a,
                                                          input logic [DATA_W-1:0] amt);
        if (|amt[DATA_W-1:5]) shiftRightLogic = '0;
        else                  shiftRightLogic = a >> amt[4:0];
    endfunction

    function automatic logic [DATA_W-1:0] shiftRightArith(input logic [DATA_W-1:0] a,
                                                          input logic [DATA_W-1:0] amt);
        logic signed [DATA_W-1:0] aSigned;
        aSigned = a;
        if (|amt[DATA_W-1:5]) shiftRightArith = {DATA_W{a[DATA_W-1]}};
        else                  shiftRightArith = aSigned >>> amt[4:0];
    endfunction

    // Result of any op that completes at the accept edge. div/mod only
    // reach here with a zero divisor, and mul only when MUL_CYCLES == 1.
    function automatic logic [DATA_W-1:0] singleCycleResult(input logic [3:0] code,
                                                            input logic [DATA_W-1:0] a,
                                                            input logic [DATA_W-1:0] b);
        case (code)
            OP_ADD:  singleCycleResult = a + b;
            OP_SUB:  singleCycleResult = a - b;
            OP_MUL:  singleCycleResult = a * b;
            OP_OR:   singleCycleResult = a | b;
            OP_AND:  singleCycleResult = a & b;
            OP_NOT:  singleCycleResult = ~a;
            OP_MOV:  singleCycleResult = b;
            OP_LSL:  singleCycleResult = shiftLeft(a, b);
            OP_LSR:  singleCycleResult = shiftRightLogic(a, b);
            OP_ASR:  singleCycleResult = shiftRightArith(a, b);
            default: singleCycleResult = '0;  // div/mod by zero, cmp, illegal
        endcase
    endfunction

    stateT              state;
    stateT              stateNext;
    logic [4:0]         count;
    logic [4:0]         countNext;
    logic               outValidR;
    logic [DATA_W-1:0]  resultR;
    logic               flagEqR;
    logic               flagGtR;

    logic [DATA_W-1:0]  mulA;
    logic [DATA_W-1:0]  mulB;
    logic [DATA_W-1:0]  dividend;   // shifts left; ends up holding the quotient
    logic [DATA_W-1:0]  divisor;
    logic [DATA_W-1:0]  remainder;
    logic               divIsMod;

    logic               slotFree;
    logic               accept;
    logic               startMul;
    logic               startDiv;
    logic               complete;
    logic [DATA_W-1:0]  completeVal;
    logic               divStep;
    logic [DATA_W-1:0]  mulLow;
    logic [DATA_W:0]    remShift;
    logic [DATA_W:0]    remDiff;
    logic               stepGe;
    logic [DATA_W-1:0]  remStep;
    logic [DATA_W-1:0]  dividendStep;

    assign slotFree = !outValidR || out_ready;
    assign in_ready = (state == IDLE) && slotFree && !reset;
    assign accept   = in_valid && in_ready;
    assign startMul = accept && MUL_MULTI && (op == OP_MUL);
    assign startDiv = accept && ((op == OP_DIV) || (op == OP_MOD)) && (B != '0);

    assign mulLow = mulA * mulB;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    assign remShift     = {remainder, dividend[DATA_W-1]};
    assign remDiff      = remShift - {1'b0, divisor};
    assign stepGe       = !remDiff[DATA_W];
    assign remStep      = stepGe ? remDiff[DATA_W-1:0] : remShift[DATA_W-1:0];
    assign dividendStep = {dividend[DATA_W-2:0], stepGe};

    always_comb begin
        stateNext   = state;
        countNext   = count;
        complete    = 1'b0;
        completeVal = '0;
        divStep     = 1'b0;
        case (state)
            IDLE: begin
                if (startMul) begin
                    stateNext = MUL;
                    countNext = MUL_LOAD;
                end else if (startDiv) begin
                    stateNext = DIV;
                    countNext = 5'd31;
                end else if (accept) begin
                    complete    = 1'b1;
                    completeVal = singleCycleResult(op, A, B);
                end
            end
            MUL: begin
                // The cycle that sees count==1 is the last multiply cycle;
                // count parks at 0 if the output slot is still occupied.
                if (count > 5'd1) begin
                    countNext = count - 5'd1;
                end else begin
                    countNext = '0;
                    if (slotFree) begin
                        complete    = 1'b1;
                        completeVal = mulLow;
                        stateNext   = IDLE;
                    end
                end
            end
            DIV: begin
                if (count != 5'd0) begin
                    countNext = count - 5'd1;
                    divStep   = 1'b1;
                end else if (slotFree) begin
                    // The final step is withheld until the slot can take it.
                    divStep     = 1'b1;
                    complete    = 1'b1;
                    completeVal = divIsMod ? remStep : dividendStep;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            outValidR <= 1'b0;
            resultR   <= '0;
            flagEqR   <= 1'b0;
            flagGtR   <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (complete) begin
                outValidR <= 1'b1;
                resultR   <= completeVal;
            end else if (out_ready) begin
                outValidR <= 1'b0;
            end
            if (accept && (op == OP_CMP)) begin
                flagEqR <= (A == B);
                flagGtR <= (A > B);
            end
        end
    end

    // Operand and divider working registers need no reset: they are
    // always loaded at accept before being used.
    always_ff @(posedge clk) begin
        if (startMul) begin
            mulA <= A;
            mulB <= B;
        end
        if (startDiv) begin
            dividend  <= A;
            divisor   <= B;
            remainder <= '0;
            divIsMod  <= (op == OP_MOD);
        end else if (divStep) begin
            dividend  <= dividendStep;
            remainder <= remStep;
        end
    end

    assign out_valid = outValidR;
    assign result    = resultR;
    assign flag_eq   = flagEqR;
    assign flag_gt   = flagGtR;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int MULC = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_eq;
    logic        flag_gt;

    alu_op_sequencer #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_eq(flag_eq), .flag_gt(flag_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec  = 0;
    int nFail = 0;
    int tick  = 0;
    bit checkEn = 1'b0;

    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (tick %0d)", name, got, exp, tick);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] refResult(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (b == 0) ? 32'd0 : a / b;
            4'd4:  return (b == 0) ? 32'd0 : a % b;
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  return ~a;
            4'd9:  return b;
            4'd10: return (b >= 32) ? 32'd0 : a << b;
            4'd11: return (b >= 32) ? 32'd0 : a >> b;
            4'd12: return (b >= 32) ? (a[31] ? 32'hFFFF_FFFF : 32'd0) : 32'(sa >>> b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int refLatency(input logic [3:0] o, input logic [31:0] b);
        if (o == 4'd2) return MULC;
        if ((o == 4'd3 || o == 4'd4) && b != 0) return 33;
        return 1;
    endfunction

    bit          mSlotValid = 1'b0;
    logic [31:0] mSlotResult = '0;
    bit          mBusy = 1'b0;
    logic [31:0] mPendResult = '0;
    int          mDoneAt = 0;
    bit          mEq = 1'b0;
    bit          mGt = 1'b0;

    // Compare on every falling edge, then advance the model across the
    // coming rising edge using the inputs that are stable now.
    always @(negedge clk) begin
        bit expReady;
        int lat;
        expReady = !reset && !mBusy && (!mSlotValid || out_ready);
        if (checkEn) begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, expReady});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, mSlotValid});
            if (mSlotValid) chk("m_result", result, mSlotResult);
            chk("m_flag_eq", {31'd0, flag_eq}, {31'd0, mEq});
            chk("m_flag_gt", {31'd0, flag_gt}, {31'd0, mGt});
        end
        if (reset) begin
            mSlotValid  = 1'b0;
            mSlotResult = '0;
            mBusy       = 1'b0;
            mEq         = 1'b0;
            mGt         = 1'b0;
        end else begin
            if (mSlotValid && out_ready) mSlotValid = 1'b0;
            if (mBusy && (tick + 1 >= mDoneAt) && !mSlotValid) begin
                mSlotValid  = 1'b1;
                mSlotResult = mPendResult;
                mBusy       = 1'b0;
            end
            if (in_valid && expReady) begin
                lat = refLatency(op, B);
                if (lat == 1) begin
                    mSlotValid  = 1'b1;
                    mSlotResult = refResult(op, A, B);
                    if (op == 4'd5) begin
                        mEq = (A == B);
                        mGt = (A > B);
                    end
                end else begin
                    mBusy       = 1'b1;
                    mPendResult = refResult(op, A, B);
                    mDoneAt     = tick + lat;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns once the op has transferred.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int acc);
        bit got;
        got = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                acc = tick;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) begin
            nVec++;
            nFail++;
            $display("FAIL issue_timeout: op %0d never accepted, expected acceptance", o);
        end
    endtask

    task automatic waitOut(input string name, input logic [31:0] expVal, input int expLat,
                           input int acc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            nVec++;
            nFail++;
            $display("FAIL %s_timeout: out_valid stayed 0, expected a result", name);
        end else begin
            chk(name, result, expVal);
            chk($sformatf("%s_lat", name), 32'(tick - acc), 32'(expLat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vecT;

    vecT vecs[$];

    initial begin
        int acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op = '0;
        A  = '0;
        B  = '0;

        // reset state
        step();
        checkEn = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, flag_eq, flag_gt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // single-cycle issue
        issue(4'd0, 32'hFFFF_FFFF, 32'd2, acc);
        waitOut("add_wrap", 32'h0000_0001, 1, acc);
        step();

        // back-to-back add then sub
        in_valid = 1'b1; op = 4'd0; A = 32'd10; B = 32'd20;
        @(negedge clk);
        chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
        step();
        op = 4'd1; A = 32'd5; B = 32'd7;
        @(negedge clk);
        chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
        chk("b2b_res_add", result, 32'd30);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_res_sub", result, 32'hFFFF_FFFE);
        chk("b2b_valid_sub", {31'd0, out_valid}, 32'd1);
        step();

        // multiply
        issue(4'd2, 32'h0001_0000, 32'h0001_0003, acc);
        waitOut("mul", 32'h0003_0000, MULC, acc);
        step();

        // division
        vecs = '{
            '{4'd3, 32'd100,        32'd7,  32'd14,         33, "div_100_7"},
            '{4'd4, 32'd100,        32'd7,  32'd2,          33, "mod_100_7"},
            '{4'd3, 32'd5,          32'd0,  32'd0,          1,  "div_by_zero"},
            '{4'd4, 32'hFFFF_FFFF,  32'd1,  32'd0,          33, "mod_max_1"},
            '{4'd3, 32'hFFFF_FFFF,  32'd16, 32'h0FFF_FFFF,  33, "div_max_16"},
            '{4'd4, 32'd5,          32'd0,  32'd0,          1,  "mod_by_zero"}
        };
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, acc);
            waitOut(vecs[i].name, vecs[i].exp, vecs[i].lat, acc);
            step();
        end

        // flags
        issue(4'd5, 32'd3, 32'd3, acc);
        waitOut("cmp_eq_res", 32'd0, 1, acc);
        chk("cmp_eq_flags", {30'd0, flag_eq, flag_gt}, 32'b10);
        step();
        issue(4'd5, 32'h8000_0000, 32'd1, acc);
        waitOut("cmp_gt_res", 32'd0, 1, acc);
        chk("cmp_gt_flags", {30'd0, flag_eq, flag_gt}, 32'b01);
        step();
        issue(4'd0, 32'd1, 32'd1, acc);
        waitOut("add_after_cmp", 32'd2, 1, acc);
        chk("flags_kept", {30'd0, flag_eq, flag_gt}, 32'b01);
        step();

        // backpressure
        out_ready = 1'b0;
        issue(4'd0, 32'd7, 32'd8, acc);
        waitOut("bp_add", 32'd15, 1, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_res", result, 32'd15);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        step();
        out_ready = 1'b1;
        in_valid = 1'b1; op = 4'd3; A = 32'd1000; B = 32'd10;
        @(negedge clk);
        chk("bp_drain_res", result, 32'd15);
        chk("bp_drain_ready", {31'd0, in_ready}, 32'd1);
        acc = tick;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        waitOut("bp_div", 32'd100, 33, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_div_hold", result, 32'd100);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_div_drained", {31'd0, out_valid}, 32'd0);
        step();

        // shifts, logic ops, illegal
        vecs = '{
            '{4'd12, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1, "asr_40"},
            '{4'd10, 32'd1,         32'd32, 32'd0,         1, "lsl_32"},
            '{4'd12, 32'h8000_0000, 32'd4,  32'hF800_0000, 1, "asr_4"},
            '{4'd11, 32'h8000_0000, 32'd4,  32'h0800_0000, 1, "lsr_4"},
            '{4'd11, 32'hFFFF_FFFF, 32'h100, 32'd0,        1, "lsr_256"},
            '{4'd10, 32'd3,         32'd4,  32'h0000_0030, 1, "lsl_4"},
            '{4'd8,  32'h0F0F_0F0F, 32'd9,  32'hF0F0_F0F0, 1, "not"},
            '{4'd9,  32'd1,         32'hABCD_0123, 32'hABCD_0123, 1, "mov"},
            '{4'd6,  32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F, 1, "or"},
            '{4'd7,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, "and"},
            '{4'd14, 32'd5,         32'd5,  32'd0,         1, "illegal"}
        };
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, acc);
            waitOut(vecs[i].name, vecs[i].exp, vecs[i].lat, acc);
            step();
        end
        chk("illegal_flags", {30'd0, flag_eq, flag_gt}, 32'b01);

        // reset in the middle of a divide
        issue(4'd3, 32'd100, 32'd7, acc);
        while (tick < acc + 10) step();
        reset = 1'b1;
        in_valid = 1'b1; op = 4'd0; A = 32'd2; B = 32'd3;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_flags", {30'd0, flag_eq, flag_gt}, 32'd0);
        chk("rst_mid_ready_after", {31'd0, in_ready}, 32'd1);
        acc = tick;
        step();
        in_valid = 1'b0;
        waitOut("post_reset_add", 32'd5, 1, acc);
        for (int i = 0; i < 40; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
